// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit                                                               |
// | Instruction fetch: one outstanding imem request, PC-tagged response FIFO |
// | Optional: FETCH_MISALIGN_TRAP_EN (misaligned-PC fault entries)           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        instr_fault
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [31:0]      data_q [FIFO_DEPTH];
  logic [31:0]      epc_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic        w_space;
  logic        w_issue_ok;
  logic        w_fire;
  logic        w_pop;
  logic        w_rsp_push;
  logic        w_push;
  logic [31:0] w_wdata;
  logic [31:0] w_wpc;

  assign w_space = (count_q != CNT_W'(FIFO_DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q [FIFO_DEPTH];
  logic halt_q;
  logic w_misalign;
  logic w_fault_push;

  assign w_misalign   = (pc[1:0] != 2'b00);
  // A misaligned PC produces exactly one fault entry, then fetch idles until redirect.
  assign w_fault_push = (state_q == ST_REQ) && w_misalign && w_space &&
                        !redirect_valid && !halt_q;
  assign w_issue_ok   = rst && (state_q == ST_REQ) && w_space &&
                        !redirect_valid && !w_misalign;
  assign imem_req_addr = pc;
  assign w_wdata      = w_fault_push ? 32'h0000_0013 : imem_rsp_data;
  assign w_wpc        = w_fault_push ? pc : req_pc_q;
  assign instr_fault  = instr_valid && fault_q[rd_ptr_q];
`else
  logic w_unused_pc_lo;

  assign w_unused_pc_lo = ^pc[1:0];
  assign w_issue_ok     = rst && (state_q == ST_REQ) && w_space && !redirect_valid;
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign w_wdata        = imem_rsp_data;
  assign w_wpc          = req_pc_q;
`endif

  assign imem_req_valid = w_issue_ok;
  assign w_fire         = w_issue_ok && imem_req_ready;
  assign instr_valid    = (count_q != '0);
  assign w_pop          = instr_valid && instr_ready;
  assign w_rsp_push     = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_push         = w_rsp_push || w_fault_push;
`else
  assign w_push         = w_rsp_push;
`endif

  assign instr    = data_q[rd_ptr_q];
  assign instr_pc = epc_q[rd_ptr_q];

  always_comb begin
    if (!rst) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (w_fire) begin
      pc_next = pc + 32'd4;
    end else begin
      pc_next = pc;
    end
  end

  // A response always ends the outstanding request; redirect without one must drain it.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_REQ: begin
        if (w_fire) begin
          state_d  = ST_WAIT;
          req_pc_d = pc;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        epc_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        data_q[wr_ptr_q] <= w_wdata;
        epc_q[wr_ptr_q]  <= w_wpc;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fault_q[i] <= 1'b0;
      end
      halt_q <= 1'b0;
    end else begin
      if (redirect_valid) begin
        halt_q <= 1'b0;
      end else if (w_fault_push) begin
        halt_q <= 1'b1;
      end
      if (w_push && !redirect_valid) begin
        fault_q[wr_ptr_q] <= w_fault_push;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the pc register.
- Takes the current `pc`, issues one word request to instruction memory through a valid/ready handshake, and buffers responses in a small FIFO tagged with their PC.
- Presents {instr, instr_pc} to decode with valid/ready.
- Drives `pc_next` back to the pc register: pc+4 on issue, hold on stall, `redirect_pc` on redirect.

Parameters:
- RESET_PC, 32'h0000_1000, reset PC value; must match the pc register's reset value; `pc_next` output while `rst` is asserted.
- FIFO_DEPTH, 2, number of fetch buffer entries (power of two, >= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  input  32  current PC from the pc register.
- pc_next  output  32  next PC to the pc register.
- redirect_valid  input  1  branch/jump taken, flush.
- redirect_pc  input  32  redirect target.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word address of request.
- imem_rsp_valid  input  1  response data valid, one cycle.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode consumes head.
- instr  output  32  head instruction.
- instr_pc  output  32  PC of head instruction.

Behaviour:
- **Reset (rst = 0, async):**
  - FSM = REQ; FIFO empty.
  - `imem_req_valid` = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
  - `pc_next` = RESET_PC.
- **Memory protocol:**
  - Request fires when `imem_req_valid` && `imem_req_ready`.
  - At most one request outstanding.
  - Response arrives >= 1 cycle after fire, in order, never back-pressured.
- **FSM states:**
  - REQ: `imem_req_valid` = (count + 0 < FIFO_DEPTH) && !`redirect_valid`. On fire, go to WAIT and latch `req_pc` = `pc`.
  - WAIT: on `imem_rsp_valid`, push {`imem_rsp_data`, `req_pc`}, then go to REQ.
  - DRAIN: wait for the stale response and discard it; go to REQ on `imem_rsp_valid`. No requests are issued in DRAIN.
- **`imem_req_addr`** = `pc` (see optional feature for the low bits).
- **`pc_next` priority:**
  1. `redirect_valid` → `redirect_pc`
  2. request fire → `pc` + 32'd4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
  3. otherwise `pc`
- **Redirect:**
  - FIFO cleared next edge; `instr_valid` drops next cycle.
  - WAIT with no response this cycle → DRAIN.
  - WAIT with response this cycle → response discarded, go to REQ.
  - Redirect in DRAIN → stay in DRAIN, `pc_next` = `redirect_pc`.
- **FIFO:**
  - Push and pop in the same cycle are both legal; count is unchanged.
  - Pop when `instr_valid` && `instr_ready`.
  - Full blocks issue.
  - A pop in the same cycle as a redirect is still consumed by decode, but the flush wins for the storage.
  - Head outputs are registered FIFO contents; `instr`/`instr_pc` are don't-care when `instr_valid` = 0.
- **Latency:** `instr_valid` rises in the cycle after `imem_rsp_valid`. Best-case throughput is 1 instruction per 2 cycles with single-cycle memory.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN
- **Defined:**
  - Adds output `instr_fault` (1 bit), carried per FIFO entry.
  - In REQ with `pc`[1:0] != 0: no memory request; push {32'h0000_0013, `pc`, fault = 1} when the FIFO has space; `pc_next` = `pc` (fetch halts until redirect).
  - `instr_fault` is 0 on normal entries and 0 in reset.
- **Undefined:**
  - No `instr_fault` port.
  - `imem_req_addr` = {`pc`[31:2], 2'b00}; the low bits are ignored.

Test Plan:
- **Reset / sequential fetch:** `pc` = 32'h0000_1000, memory ready, 1-cycle response → requests to 1000, 1004, 1008; decode sees (1000, 1004, 1008) in order; `pc_next` = 1004 on the first fire.
- **Backpressure:** `instr_ready` = 0 → FIFO fills to 2; `imem_req_valid` = 0; `pc_next` = `pc` held. Release → entries drain in order, fetch resumes at the next PC, no drops or duplicates.
- **Redirect in WAIT (3-cycle memory latency):** `redirect_valid` with `redirect_pc` = 32'h0000_2000 → DRAIN; stale word discarded; next request at addr 2000; first decoded `instr_pc` = 2000.
- **Redirect coincident with response:** response discarded; no DRAIN; next request issues the following cycle at `redirect_pc`.
- **Async reset mid-fetch:** `rst` low in WAIT → `imem_req_valid`/`instr_valid` = 0 immediately; `pc_next` = 32'h0000_1000; a late `imem_rsp_valid` after reset is ignored.
- **Misaligned PC:**
  - With FETCH_MISALIGN_TRAP_EN, `pc` = 32'h0000_1002 → no request; `instr` = 32'h0000_0013, `instr_fault` = 1, `instr_pc` = 1002.
  - Without the macro → `imem_req_addr` = 32'h0000_1000.
